// File: rtl/stop_watch_ctrl.sv
// Button front end and IDLE/RUN/PAUSE controller for the stop watch datapath.
// Debounces start/stop and lap/clear, drives count enable/clear and freezes lap snapshots.
module stop_watch_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int LAP_W      = 4
) (
  input  logic             I_CLK,
  input  logic             I_RST,
  input  logic             I_BTN_SS,
  input  logic             I_BTN_LC,
  input  logic [9:0]       I_TIMER_MS,
  input  logic [5:0]       I_TIMER_SEC,
  output logic             O_EN1,
  output logic             O_EN2,
  output logic [9:0]       O_LAP_MS,
  output logic [5:0]       O_LAP_SEC,
  output logic             O_LAP_VALID,
  output logic [LAP_W-1:0] O_LAP_CNT,
  output logic [1:0]       O_STATE
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEB_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  function automatic logic [LAP_W-1:0] sat_inc(input logic [LAP_W-1:0] v);
    return (v == {LAP_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Bit 0 is start/stop, bit 1 is lap/clear
  logic [1:0]       sync_p0, sync_p1;
  logic [1:0]       deb_p2, deb_d_p3;
  logic [1:0]       press_p3;
  logic [CNT_W-1:0] cnt_p2 [2];

  state_t state, next_state;
  logic   do_lap, do_clr;
  logic   ss_p, lc_p;

  assign ss_p = press_p3[0];
  assign lc_p = press_p3[1];

  // Synchroniser, debounce and press-edge stages
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      deb_p2   <= '0;
      deb_d_p3 <= '0;
      press_p3 <= '0;
      for (int i = 0; i < 2; i++) cnt_p2[i] <= '0;
    end else begin
      sync_p0  <= {I_BTN_LC, I_BTN_SS};
      sync_p1  <= sync_p0;
      deb_d_p3 <= deb_p2;
      press_p3 <= deb_p2 & ~deb_d_p3;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == deb_p2[i]) begin
          cnt_p2[i] <= '0;
        end else if (cnt_p2[i] == CNT_TOP) begin
          cnt_p2[i] <= '0;
          deb_p2[i] <= ~deb_p2[i];
        end else begin
          cnt_p2[i] <= cnt_p2[i] + 1'b1;
        end
      end
    end
  end

  // Controller state register
  always_ff @(posedge I_CLK) begin
    if (I_RST) state <= IDLE;
    else       state <= next_state;
  end

  // Start/stop takes priority; a coincident lap/clear press is dropped
  always_comb begin
    next_state = state;
    do_lap     = 1'b0;
    do_clr     = 1'b0;
    case (state)
      IDLE: begin
        if (ss_p)      next_state = RUN;
        else if (lc_p) do_clr = 1'b1;
      end
      RUN: begin
        if (ss_p)      next_state = PAUSE;
        else if (lc_p) do_lap = 1'b1;
      end
      PAUSE: begin
        if (ss_p) begin
          next_state = RUN;
        end else if (lc_p) begin
          next_state = IDLE;
          do_clr     = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output register stage
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      O_EN1       <= 1'b0;
      O_EN2       <= 1'b0;
      O_LAP_VALID <= 1'b0;
      O_LAP_MS    <= '0;
      O_LAP_SEC   <= '0;
      O_LAP_CNT   <= '0;
    end else begin
      O_EN1       <= (next_state == RUN);
      O_EN2       <= do_clr;
      O_LAP_VALID <= do_lap;
      if (do_clr) begin
        O_LAP_MS  <= '0;
        O_LAP_SEC <= '0;
        O_LAP_CNT <= '0;
      end else if (do_lap) begin
        O_LAP_MS  <= I_TIMER_MS;
        O_LAP_SEC <= I_TIMER_SEC;
        O_LAP_CNT <= sat_inc(O_LAP_CNT);
      end
    end
  end

  assign O_STATE = state;

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Directed bench for stop_watch_ctrl: latency, glitch rejection, laps, clear, priority and reset.
module tb_stop_watch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_ss, btn_lc;
  logic [9:0] timer_ms;
  logic [5:0] timer_sec;
  logic       en1, en2, lap_valid;
  logic [9:0] lap_ms;
  logic [5:0] lap_sec;
  logic [3:0] lap_cnt;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  stop_watch_ctrl #(.DEB_CYCLES(16), .LAP_W(4)) dut (
    .I_CLK(clk), .I_RST(rst), .I_BTN_SS(btn_ss), .I_BTN_LC(btn_lc),
    .I_TIMER_MS(timer_ms), .I_TIMER_SEC(timer_sec),
    .O_EN1(en1), .O_EN2(en2), .O_LAP_MS(lap_ms), .O_LAP_SEC(lap_sec),
    .O_LAP_VALID(lap_valid), .O_LAP_CNT(lap_cnt), .O_STATE(state)
  );

  always #5 clk = ~clk;

  // Hold the chosen buttons 40 cycles, release for 40, counting output pulses
  task automatic press(input logic ss, input logic lc, output int nv, output int ne);
    nv = 0;
    ne = 0;
    @(negedge clk);
    btn_ss = ss;
    btn_lc = lc;
    repeat (40) begin
      @(negedge clk);
      nv += int'(lap_valid);
      ne += int'(en2);
    end
    btn_ss = 1'b0;
    btn_lc = 1'b0;
    repeat (40) begin
      @(negedge clk);
      nv += int'(lap_valid);
      ne += int'(en2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_ss = 1'b0; btn_lc = 1'b0; timer_ms = '0; timer_sec = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({en1, en2, lap_valid, lap_ms, lap_sec, lap_cnt, state} !== 25'd0) begin
      n_err++; $display("FAIL reset_outputs got=%h want=0", {en1, en2, lap_valid, lap_ms, lap_sec, lap_cnt, state});
    end
    rst = 1'b0;
  endtask

  task automatic test_start_latency();
    @(negedge clk);
    btn_ss = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (state !== 2'b00) begin n_err++; $display("FAIL start_edge19_state got=%b want=00", state); end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (state !== 2'b01 || en1 !== 1'b1) begin
      n_err++; $display("FAIL start_edge20 got state=%b en1=%b want state=01 en1=1", state, en1);
    end
    repeat (18) @(negedge clk);
    btn_ss = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp++;
    if (state !== 2'b01) begin n_err++; $display("FAIL start_single_transition got=%b want=01", state); end
  endtask

  task automatic test_glitch_and_pause();
    int nv, ne;
    @(negedge clk);
    btn_ss = 1'b1;
    repeat (10) @(negedge clk);
    btn_ss = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp++;
    if (state !== 2'b01 || en1 !== 1'b1) begin
      n_err++; $display("FAIL glitch_reject got state=%b en1=%b want 01/1", state, en1);
    end
    press(1'b1, 1'b0, nv, ne);
    n_cmp++;
    if (state !== 2'b10 || en1 !== 1'b0) begin
      n_err++; $display("FAIL pause got state=%b en1=%b want 10/0", state, en1);
    end
    press(1'b1, 1'b0, nv, ne);
    n_cmp++;
    if (state !== 2'b01 || en1 !== 1'b1 || ne !== 0) begin
      n_err++; $display("FAIL resume got state=%b en1=%b en2_pulses=%0d want 01/1/0", state, en1, ne);
    end
  endtask

  task automatic test_lap();
    int nv, ne, tot;
    timer_ms = 10'd123;
    timer_sec = 6'd7;
    press(1'b0, 1'b1, nv, ne);
    n_cmp++;
    if (nv !== 1 || lap_ms !== 10'd123 || lap_sec !== 6'd7 || lap_cnt !== 4'd1) begin
      n_err++; $display("FAIL first_lap got valid=%0d ms=%0d sec=%0d cnt=%0d want 1/123/7/1", nv, lap_ms, lap_sec, lap_cnt);
    end
    n_cmp++;
    if (state !== 2'b01 || en1 !== 1'b1) begin
      n_err++; $display("FAIL lap_stays_run got state=%b en1=%b want 01/1", state, en1);
    end
    tot = 0;
    for (int i = 0; i < 17; i++) begin
      timer_ms = 10'(200 + i);
      press(1'b0, 1'b1, nv, ne);
      tot += nv;
    end
    n_cmp++;
    if (lap_cnt !== 4'd15 || tot !== 17) begin
      n_err++; $display("FAIL lap_saturate got cnt=%0d pulses=%0d want 15/17", lap_cnt, tot);
    end
    n_cmp++;
    if (lap_ms !== 10'd216) begin n_err++; $display("FAIL lap_latest_ms got=%0d want=216", lap_ms); end
  endtask

  task automatic test_both_buttons();
    int nv, ne;
    press(1'b1, 1'b1, nv, ne);
    n_cmp++;
    if (state !== 2'b10 || nv !== 0 || lap_cnt !== 4'd15 || ne !== 0) begin
      n_err++; $display("FAIL both_buttons got state=%b valid=%0d cnt=%0d en2=%0d want 10/0/15/0", state, nv, lap_cnt, ne);
    end
  endtask

  task automatic test_clear();
    int nv, ne;
    press(1'b0, 1'b1, nv, ne);
    n_cmp++;
    if (ne !== 1 || state !== 2'b00 || en1 !== 1'b0) begin
      n_err++; $display("FAIL pause_clear got en2=%0d state=%b en1=%b want 1/00/0", ne, state, en1);
    end
    n_cmp++;
    if (lap_ms !== 10'd0 || lap_sec !== 6'd0 || lap_cnt !== 4'd0) begin
      n_err++; $display("FAIL clear_laps got ms=%0d sec=%0d cnt=%0d want 0/0/0", lap_ms, lap_sec, lap_cnt);
    end
    press(1'b0, 1'b1, nv, ne);
    n_cmp++;
    if (ne !== 1 || state !== 2'b00) begin
      n_err++; $display("FAIL idle_reclear got en2=%0d state=%b want 1/00", ne, state);
    end
  endtask

  task automatic test_mid_reset();
    int nv, ne, e2;
    press(1'b1, 1'b0, nv, ne);
    timer_ms = 10'd500;
    timer_sec = 6'd30;
    press(1'b0, 1'b1, nv, ne);
    n_cmp++;
    if (state !== 2'b01 || lap_ms !== 10'd500 || lap_sec !== 6'd30 || lap_cnt !== 4'd1) begin
      n_err++; $display("FAIL prereset_lap got state=%b ms=%0d sec=%0d cnt=%0d want 01/500/30/1", state, lap_ms, lap_sec, lap_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({en1, en2, lap_valid, lap_ms, lap_sec, lap_cnt, state} !== 25'd0) begin
      n_err++; $display("FAIL mid_reset got=%h want=0", {en1, en2, lap_valid, lap_ms, lap_sec, lap_cnt, state});
    end
    e2 = 0;
    repeat (30) begin
      @(negedge clk);
      e2 += int'(en2);
    end
    n_cmp++;
    if (e2 !== 0 || state !== 2'b00) begin
      n_err++; $display("FAIL post_reset got en2=%0d state=%b want 0/00", e2, state);
    end
  endtask

  initial begin
    test_reset();
    test_start_latency();
    test_glitch_and_pause();
    test_lap();
    test_both_buttons();
    test_clear();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
